// File: rtl/bp_core_cache_req_arbiter.sv
// Two-way (I$ = 0, D$ = 1) arbiter that shares one downstream cache-service request channel.
// Define BP_CACHE_ARB_DCACHE_PRIO_EN for fixed D$ priority; round-robin otherwise.
module bp_core_cache_req_arbiter #(
    parameter int req_width_p      = 128,
    parameter int metadata_width_p = 8,
    parameter int num_req_p        = 2
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [num_req_p*req_width_p-1:0]      req_i,
    input  logic [num_req_p-1:0]                  req_v_i,
    output logic [num_req_p-1:0]                  req_ready_o,
    input  logic [num_req_p*metadata_width_p-1:0] req_metadata_i,
    input  logic [num_req_p-1:0]                  req_metadata_v_i,
    output logic [num_req_p-1:0]                  req_complete_o,
    output logic [num_req_p-1:0]                  req_critical_o,
    output logic [req_width_p-1:0]                cache_req_o,
    output logic                                  cache_req_v_o,
    input  logic                                  cache_req_ready_i,
    output logic [metadata_width_p-1:0]           cache_req_metadata_o,
    output logic                                  cache_req_metadata_v_o,
    input  logic                                  cache_req_complete_i,
    input  logic                                  cache_req_critical_i,
    output logic                                  cache_req_owner_o
);

    typedef enum logic [1:0] {
        e_ready     = 2'd0,
        e_wait_meta = 2'd1,
        e_busy      = 2'd2
    } state_e;

    state_e state;
    logic   owner;
    logic   grant;
    logic   sel;

    logic [req_width_p-1:0]      req_arr  [num_req_p];
    logic [metadata_width_p-1:0] meta_arr [num_req_p];

    for (genvar i = 0; i < num_req_p; i++) begin : g_unpack
        assign req_arr[i]  = req_i[i*req_width_p +: req_width_p];
        assign meta_arr[i] = req_metadata_i[i*metadata_width_p +: metadata_width_p];
    end

`ifdef BP_CACHE_ARB_DCACHE_PRIO_EN
    // D$ wins any tie; otherwise the lone valid requester is granted.
    assign grant = req_v_i[1];
`else
    logic rr_ptr;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant = req_v_i[1];
        if (&req_v_i) begin
            grant = rr_ptr;
        end
    end
`endif

    // Request data follows the grant while arbitrating and the owner afterwards.
    assign sel                  = (state == e_ready) ? grant : owner;
    assign cache_req_o          = req_arr[sel];
    assign cache_req_metadata_o = meta_arr[owner];
    assign cache_req_owner_o    = owner;

    always_comb begin
        cache_req_v_o          = 1'b0;
        cache_req_metadata_v_o = 1'b0;
        req_ready_o            = '0;
        req_complete_o         = '0;
        req_critical_o         = '0;
        if (!reset_i) begin
            unique case (state)
                e_ready: begin
                    cache_req_v_o      = |req_v_i;
                    req_ready_o[grant] = cache_req_ready_i & req_v_i[grant];
                end
                e_wait_meta: begin
                    cache_req_metadata_v_o = req_metadata_v_i[owner];
                    req_complete_o[owner]  = cache_req_complete_i;
                    req_critical_o[owner]  = cache_req_critical_i;
                end
                e_busy: begin
                    req_complete_o[owner] = cache_req_complete_i;
                    req_critical_o[owner] = cache_req_critical_i;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= e_ready;
            owner <= 1'b0;
`ifndef BP_CACHE_ARB_DCACHE_PRIO_EN
            rr_ptr <= 1'b0;
`endif
        end else begin
            unique case (state)
                e_ready: begin
                    if ((|req_v_i) && cache_req_ready_i) begin
                        owner <= grant;
                        state <= e_wait_meta;
                    end
                end
                e_wait_meta, e_busy: begin
                    if (cache_req_complete_i) begin
                        // Completion ends ownership even if metadata never arrived.
                        state <= e_ready;
`ifndef BP_CACHE_ARB_DCACHE_PRIO_EN
                        rr_ptr <= ~owner;
`endif
                    end else if (state == e_wait_meta && req_metadata_v_i[owner]) begin
                        state <= e_busy;
                    end
                end
                default: state <= e_ready;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_core_cache_req_arbiter.sv
// Randomized bench for bp_core_cache_req_arbiter against a transaction-level reference model.
// Honours BP_CACHE_ARB_DCACHE_PRIO_EN when predicting tie-break winners.
module tb_bp_core_cache_req_arbiter;

    localparam int RW = 128;
    localparam int MW = 8;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [2*RW-1:0] req_i;
    logic [1:0]      req_v_i;
    logic [1:0]      req_ready_o;
    logic [2*MW-1:0] req_metadata_i;
    logic [1:0]      req_metadata_v_i;
    logic [1:0]      req_complete_o;
    logic [1:0]      req_critical_o;
    logic [RW-1:0]   cache_req_o;
    logic            cache_req_v_o;
    logic            cache_req_ready_i;
    logic [MW-1:0]   cache_req_metadata_o;
    logic            cache_req_metadata_v_o;
    logic            cache_req_complete_i;
    logic            cache_req_critical_i;
    logic            cache_req_owner_o;

    bp_core_cache_req_arbiter #(.req_width_p(RW), .metadata_width_p(MW), .num_req_p(2)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_i(req_i), .req_v_i(req_v_i), .req_ready_o(req_ready_o),
        .req_metadata_i(req_metadata_i), .req_metadata_v_i(req_metadata_v_i),
        .req_complete_o(req_complete_o), .req_critical_o(req_critical_o),
        .cache_req_o(cache_req_o), .cache_req_v_o(cache_req_v_o),
        .cache_req_ready_i(cache_req_ready_i),
        .cache_req_metadata_o(cache_req_metadata_o), .cache_req_metadata_v_o(cache_req_metadata_v_o),
        .cache_req_complete_i(cache_req_complete_i), .cache_req_critical_i(cache_req_critical_i),
        .cache_req_owner_o(cache_req_owner_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Requester side: outstanding request per cache and its payload.
    logic [1:0]    pend = 2'b00;
    logic [RW-1:0] data [2];

    // Reference model: who holds the channel, whether its metadata went through, who is preferred next.
    logic channel_free = 1'b1;
    int   holder       = 0;
    logic meta_done    = 1'b0;
    int   prefer       = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int winner(input logic [1:0] v);
        if (v == 2'b11) begin
`ifdef BP_CACHE_ARB_DCACHE_PRIO_EN
            return 1;
`else
            return prefer;
`endif
        end
        return v[1] ? 1 : 0;
    endfunction

    // One clock of stimulus: drive at negedge, check just after, advance model at posedge.
    task automatic step(input logic [1:0] v, input logic rdy, input logic cmp, input logic crit,
                        input logic [1:0] mv, input logic rst);
        logic [1:0] ev;
        logic [1:0] e_rdy, e_cmp, e_crit;
        logic       e_v, e_mv;
        int         g;
        @(negedge clk_i);
        ev = v | pend;
        for (int i = 0; i < 2; i++) begin
            if (ev[i] && !pend[i]) begin
                pend[i] = 1'b1;
                data[i] = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        reset_i              = rst;
        req_v_i              = ev;
        req_i                = {data[1], data[0]};
        req_metadata_i       = 16'($urandom);
        req_metadata_v_i     = mv;
        cache_req_ready_i    = rdy;
        cache_req_complete_i = cmp;
        cache_req_critical_i = crit;
        #1;
        g      = winner(ev);
        e_v    = 1'b0;
        e_mv   = 1'b0;
        e_rdy  = 2'b00;
        e_cmp  = 2'b00;
        e_crit = 2'b00;
        if (!rst) begin
            if (channel_free) begin
                e_v = |ev;
                e_rdy[g] = rdy & ev[g];
            end else begin
                e_cmp[holder]  = cmp;
                e_crit[holder] = crit;
                e_mv = !meta_done && mv[holder];
            end
            check("owner", 128'(cache_req_owner_o), 128'(holder));
        end
        check("req_v", 128'(cache_req_v_o), 128'(e_v));
        check("ready", 128'(req_ready_o), 128'(e_rdy));
        check("complete", 128'(req_complete_o), 128'(e_cmp));
        check("critical", 128'(req_critical_o), 128'(e_crit));
        check("meta_v", 128'(cache_req_metadata_v_o), 128'(e_mv));
        if (e_v) check("req_data", cache_req_o, data[g]);
        if (e_mv) check("meta_data", 128'(cache_req_metadata_o), 128'(req_metadata_i[holder*MW +: MW]));
        @(posedge clk_i);
        if (rst) begin
            channel_free = 1'b1;
            holder       = 0;
            prefer       = 0;
        end else if (channel_free) begin
            if ((|ev) && rdy) begin
                channel_free = 1'b0;
                holder       = g;
                meta_done    = 1'b0;
                pend[g]      = 1'b0;
            end
        end else if (cmp) begin
            channel_free = 1'b1;
            prefer       = 1 - holder;
        end else if (!meta_done && mv[holder]) begin
            meta_done = 1'b1;
        end
    endtask

    initial begin
        reset_i = 1'b1; req_v_i = '0; req_i = '0; req_metadata_i = '0; req_metadata_v_i = '0;
        cache_req_ready_i = 1'b0; cache_req_complete_i = 1'b0; cache_req_critical_i = 1'b0;
        data[0] = '0; data[1] = '0;

        // Reset, then a lone I$ transaction with a delayed completion.
        step(2'b00, 1, 0, 0, 2'b00, 1);
        step(2'b00, 1, 0, 0, 2'b00, 1);
        step(2'b00, 1, 0, 0, 2'b00, 0);
        step(2'b01, 1, 0, 0, 2'b00, 0);
        step(2'b00, 1, 0, 0, 2'b01, 0);
        for (int i = 0; i < 4; i++) step(2'b00, 1, 0, 0, 2'b00, 0);
        step(2'b00, 1, 1, 0, 2'b00, 0);
        step(2'b00, 1, 0, 0, 2'b00, 0);

        // Both requesting repeatedly: alternation (or D$ always under fixed priority).
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 1, 0, 0, 2'b00, 0);
            step(2'b11, 0, 0, 0, 2'b11, 0);
            step(2'b11, 0, 1, 0, 2'b00, 0);
        end
        step(2'b00, 0, 0, 0, 2'b00, 0);
        step(2'b00, 1, 0, 0, 2'b00, 0);
        step(2'b00, 1, 0, 0, 2'b00, 0);

        // D$ held off by downstream back-pressure, then critical ahead of completion.
        for (int i = 0; i < 4; i++) step(2'b10, 0, 0, 0, 2'b00, 0);
        step(2'b10, 1, 0, 0, 2'b00, 0);
        step(2'b00, 0, 0, 0, 2'b10, 0);
        step(2'b00, 0, 0, 1, 2'b00, 0);
        step(2'b00, 0, 0, 0, 2'b00, 0);
        step(2'b00, 0, 1, 0, 2'b00, 0);

        // Completion before metadata; late metadata must be dropped.
        step(2'b01, 1, 0, 0, 2'b00, 0);
        step(2'b00, 0, 1, 0, 2'b00, 0);
        step(2'b00, 0, 0, 0, 2'b01, 0);

        // Reset while busy, then a normal I$ grant.
        step(2'b10, 1, 0, 0, 2'b00, 0);
        step(2'b00, 0, 0, 0, 2'b10, 0);
        step(2'b00, 0, 0, 0, 2'b00, 1);
        step(2'b01, 1, 0, 0, 2'b00, 0);
        step(2'b00, 0, 1, 0, 2'b01, 0);

        // Randomized traffic including stray completions and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            step({1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0)},
                 1'($urandom), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0),
                 2'($urandom), 1'($urandom_range(0, 149) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
